// File: rtl/pump_pwm_gen.sv
// Dual-channel pump PWM generator. Duty commands take effect only at period
// boundaries; increases are slew-limited, decreases apply immediately.
module pump_pwm_gen #(
  parameter int PRESCALE     = 196,
  parameter int RAMP_STEP    = 8,
  parameter int RAMP_PERIODS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty_target_a,
  input  logic [7:0] duty_target_b,
  input  logic       enable,
  output logic       pwm_a,
  output logic       pwm_b,
  output logic [7:0] duty_active_a,
  output logic [7:0] duty_active_b,
  output logic       period_start,
  output logic       ramping
);

  localparam logic [11:0] PRESC_LAST = 12'(PRESCALE - 1);
  localparam logic [7:0]  RAMP_LAST  = 8'(RAMP_PERIODS - 1);
  localparam logic [8:0]  STEP9      = 9'(RAMP_STEP);
  localparam logic [7:0]  PWM_LAST   = 8'd254;

  logic [11:0]     r_presc_cnt, w_presc_next;
  logic [7:0]      r_pwm_cnt, w_pwm_next;
  logic [7:0]      r_ramp_cnt, w_ramp_next;
  logic [1:0][7:0] r_duty, w_duty_next;
  logic [1:0][7:0] r_tgt, w_tgt_next;
  logic [1:0][7:0] w_target;
  logic [1:0]      r_pwm, w_pwm_bits;
  logic            r_period_start, r_ramping, w_ramping_next;
  logic            w_tick, w_boundary, w_ramp_due;

  // Sum is formed at 9 bits so a large step clamps to the target instead of wrapping.
  function automatic logic [7:0] f_duty_next(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic       ramp_due);
    logic [8:0] sum;
    sum = {1'b0, cur} + STEP9;
    if (tgt < cur)
      return tgt;
    else if ((tgt > cur) && ramp_due)
      return (sum > {1'b0, tgt}) ? tgt : sum[7:0];
    else
      return cur;
  endfunction

  always_comb begin
    w_target[0] = duty_target_a;
    w_target[1] = duty_target_b;
    w_tick      = (r_presc_cnt == PRESC_LAST);
    w_boundary  = w_tick && (r_pwm_cnt == PWM_LAST);
    w_ramp_due  = (r_ramp_cnt == RAMP_LAST);

    w_presc_next = w_tick ? 12'd0 : r_presc_cnt + 12'd1;
    w_pwm_next   = r_pwm_cnt;
    if (w_tick)
      w_pwm_next = (r_pwm_cnt == PWM_LAST) ? 8'd0 : r_pwm_cnt + 8'd1;

    w_ramp_next = r_ramp_cnt;
    if (!enable)
      w_ramp_next = 8'd0;
    else if (w_boundary)
      w_ramp_next = w_ramp_due ? 8'd0 : r_ramp_cnt + 8'd1;

    for (int i = 0; i < 2; i++) begin
      w_tgt_next[i]  = w_boundary ? w_target[i] : r_tgt[i];
      w_duty_next[i] = r_duty[i];
      if (!enable)
        w_duty_next[i] = 8'd0;
      else if (w_boundary)
        w_duty_next[i] = f_duty_next(r_duty[i], w_target[i], w_ramp_due);
      // Compare against next-state values so the output lines up with pwm_cnt.
      w_pwm_bits[i] = enable && (w_pwm_next < w_duty_next[i]);
    end

    w_ramping_next = enable && ((w_duty_next[0] < w_tgt_next[0]) ||
                                (w_duty_next[1] < w_tgt_next[1]));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc_cnt    <= '0;
      r_pwm_cnt      <= '0;
      r_ramp_cnt     <= '0;
      r_duty         <= '0;
      r_tgt          <= '0;
      r_pwm          <= '0;
      r_period_start <= 1'b0;
      r_ramping      <= 1'b0;
    end else begin
      r_presc_cnt    <= w_presc_next;
      r_pwm_cnt      <= w_pwm_next;
      r_ramp_cnt     <= w_ramp_next;
      r_duty         <= w_duty_next;
      r_tgt          <= w_tgt_next;
      r_pwm          <= w_pwm_bits;
      r_period_start <= w_boundary;
      r_ramping      <= w_ramping_next;
    end
  end

  assign pwm_a         = r_pwm[0];
  assign pwm_b         = r_pwm[1];
  assign duty_active_a = r_duty[0];
  assign duty_active_b = r_duty[1];
  assign period_start  = r_period_start;
  assign ramping       = r_ramping;

endmodule

// File: doc/pump_pwm_gen.md
Name: pump_pwm_gen

Overview:
Dual-channel PWM generator that drives pump A and pump B from the 8-bit duty commands produced by the filter control FSM.
- New duty commands are applied only at PWM period boundaries, so output pulses are never truncated or glitched.
- Duty increases are slew-limited (soft start) to limit inrush current; duty decreases are applied immediately.
- Outputs connect directly to the pump driver pins.

Parameters:
PRESCALE, 196, clk cycles per PWM tick (range 1..4095); 50 MHz / (196 × 255) ≈ 1 kHz PWM.
RAMP_STEP, 8, maximum duty increase per ramp update (range 1..255).
RAMP_PERIODS, 4, PWM periods between ramp updates (range 1..255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
duty_target_a  in  8  commanded duty, pump A (0..255)
duty_target_b  in  8  commanded duty, pump B (0..255)
enable  in  1  1 = run; 0 = force both pumps off and clear ramp state
pwm_a  out  1  registered PWM output, pump A
pwm_b  out  1  registered PWM output, pump B
duty_active_a  out  8  duty currently applied, pump A
duty_active_b  out  8  duty currently applied, pump B
period_start  out  1  one-clk pulse in the cycle pwm_cnt becomes 0
ramping  out  1  1 while either duty_active is below its sampled target

Behaviour:
- Reset (async): presc_cnt=0, pwm_cnt=0, ramp_cnt=0, duty_active_a/b=0, tgt_a/b=0, pwm_a/b=0, period_start=0, ramping=0.
- Prescaler: presc_cnt counts 0..PRESCALE-1, then wraps. tick = (presc_cnt==PRESCALE-1).
- PWM counter: advances on tick, 0..254, wraps 254→0. Period = 255 ticks = 255×PRESCALE clk.
- Boundary: boundary = tick && pwm_cnt==254. period_start is registered and is high exactly in the cycle pwm_cnt==0 first holds after a wrap. No period_start is generated out of reset.
- Output compare: pwm_x <= enable && (pwm_cnt_next < duty_active_x_next). This is registered and aligned with pwm_cnt.
  - pwm_x is high for exactly duty_active_x ticks per period.
  - duty 0 gives a constant 0; duty 255 gives a constant 1.
- Target sampling: at every boundary, tgt_x <= duty_target_x. Inputs are ignored between boundaries.
- Duty update at a boundary:
  - If duty_target_x < duty_active_x: duty_active_x <= duty_target_x immediately, regardless of ramp_cnt.
  - If greater and ramp_cnt==RAMP_PERIODS-1: duty_active_x <= min(duty_active_x + RAMP_STEP, duty_target_x). The sum is computed at 9 bits, so there is no overshoot and no 8-bit wrap.
  - Otherwise duty_active_x holds.
  - Both channels update independently in the same cycle.
- ramp_cnt: increments at each boundary and wraps RAMP_PERIODS-1→0. Free-running while enable=1.
- ramping = (duty_active_a < tgt_a) || (duty_active_b < tgt_b).
- enable=0, any cycle:
  - next clk: pwm_a/b=0, duty_active_a/b=0, ramp_cnt=0, ramping=0.
  - presc_cnt and pwm_cnt keep running.
- enable 0→1: the ramp starts from 0 at the next boundary that satisfies the ramp rule. Pumps always soft-start after a disable.
- Target change mid-period: no effect until the next boundary.
- Simultaneous enable=0 and boundary: enable wins; duty_active=0.
- Reset mid-period: outputs go low asynchronously; the full state clears as specified above.

Test Plan:
1. Bench parameters PRESCALE=2, RAMP_STEP=50, RAMP_PERIODS=1; enable=1; target_a 0→230 → duty_active_a steps 50,100,150,200,230 at 5 consecutive boundaries; ramping clears after 230; pwm_a high 460 of 510 clk in the final period.
2. Target_a 230→77 at steady state → duty_active_a=77 at the next boundary, no ramp; pwm_a high 154 clk per period.
3. Target 0 and target 255 on both channels for 3 periods → pwm constant 0 and constant 1 respectively; period_start pulses every 510 clk.
4. Deassert enable mid-period at duty 230 → pwm_a/b=0 and duty_active=0 one clk later. Re-enable → ramp restarts at 50.
5. Bench parameter RAMP_PERIODS=3, target 100, step 50 → increases occur only at every 3rd boundary: 50 at boundary 3, 100 at boundary 6.
6. Change the target at pwm_cnt=100, then assert reset at pwm_cnt=120 → duty_active unchanged before the boundary; after reset all outputs are 0 and period_start is first seen 510 clk after reset release.
